// File: rtl/cpu_defs.sv
// Shared fetch-path definitions: reset PC, IM address width, FSM encoding, buffer entry layout.
// No logic; imported by the fetch sequencer and its instruction buffer.
package cpu_defs;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IM_AW            = 10;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } buf_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO of {pc, instr}; head is always entry 0.
// Latency: written entry is visible on dout the next cycle.
// Backpressure: push into a full buffer is only taken alongside a pop; flush beats push and pop.
module fetch_buf
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  buf_entry_t din,
    output buf_entry_t dout,
    output logic [1:0] count
);
    buf_entry_t ent0;
    buf_entry_t ent1;
    logic       do_pop;
    logic       full;

    assign do_pop = pop && (count != 2'd0);
    assign full   = (count == 2'd2);
    assign dout   = ent0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && do_pop) begin
            // Occupancy is unchanged; shift when full so the new entry lands behind the survivor.
            if (full) begin
                ent0 <= ent1;
                ent1 <= din;
            end else begin
                ent0 <= din;
            end
        end else if (push && !full) begin
            if (count == 2'd0) begin
                ent0 <= din;
            end else begin
                ent1 <= din;
            end
            count <= count + 2'd1;
        end else if (do_pop) begin
            ent0  <= ent1;
            count <= count - 2'd1;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches from combinational IM at pc[11:2] and buffers {pc,instr} for decode.
// Latency: instruction fetched in cycle N is on out_* in cycle N+1; redirect target in N+2.
// Backpressure: out_ready low fills the 2-entry buffer, after which the PC holds.
module fetch_sequencer
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    output logic             halted
);
    localparam logic [1:0] DEPTH_L = 2'(BUF_DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] redirect_tgt;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        buf_valid;
    buf_entry_t  din;
    buf_entry_t  head;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign im_addr      = pc[IM_AW+1:2];
    assign buf_valid    = (count != 2'd0);
    assign pop          = buf_valid && out_ready;
    assign din          = '{pc: pc, instr: im_instr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_FETCH;
        end else if (state == ST_FETCH && halt_req) begin
            state_nxt = ST_HALTED;
        end
    end

    always_comb begin
        push      = (state == ST_FETCH) && !redirect_valid && !halt_req
                    && ((count < DEPTH_L) || pop);
        out_valid = buf_valid;
        out_instr = buf_valid ? head.instr : 32'h0;
        out_pc    = buf_valid ? head.pc    : 32'h0;
        halted    = (state == ST_HALTED) && !buf_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_tgt;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    fetch_buf u_fetch_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [1024];
    assign im_instr = mem[im_addr];

    // Reference model: a queue of {pc, instr}, the fetch PC and a halted flag.
    logic [63:0] mq [$];
    logic [31:0] m_pc;
    bit          m_halt;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0000_3000;
        m_halt = 1'b0;
    endtask

    task automatic check_model();
        logic        v;
        logic [63:0] h;
        v = (mq.size() != 0);
        h = v ? mq[0] : 64'h0;
        chk("out_valid", {31'h0, out_valid}, {31'h0, v});
        chk("out_pc", out_pc, h[63:32]);
        chk("out_instr", out_instr, h[31:0]);
        chk("im_addr", {22'h0, im_addr}, {22'h0, m_pc[11:2]});
        chk("halted", {31'h0, halted}, {31'h0, (m_halt && !v)});
    endtask

    // Apply one cycle of inputs at the falling edge, advance the model, check at the next falling edge.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hq);
        int sz;
        bit pop;
        out_ready      = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        halt_req       = hq;
        sz  = mq.size();
        pop = (sz > 0) && rdy;
        if (rd) begin
            mq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt && hq) begin
                m_halt = 1'b1;
            end else if (!m_halt && (sz < 2 || pop)) begin
                mq.push_back({m_pc, mem[m_pc[11:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        model_reset();
        #3;
        chk("reset im_addr", {22'h0, im_addr}, 32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_model();

        // Straight-line fetch
        step(1, 0, 0, 0);
        chk("t1 first out_pc", out_pc, 32'h3000);
        chk("t1 first instr", out_instr, mem[0]);
        step(1, 0, 0, 0);
        chk("t1 second out_pc", out_pc, 32'h3004);

        // Backpressure fills the buffer, then release
        do_reset();
        repeat (4) step(0, 0, 0, 0);
        chk("t2 held out_pc", out_pc, 32'h3000);
        chk("t2 held im_addr", {22'h0, im_addr}, 32'h2);
        step(1, 0, 0, 0);
        chk("t2 rel1", out_pc, 32'h3004);
        step(1, 0, 0, 0);
        chk("t2 rel2", out_pc, 32'h3008);

        // Redirect while full and popping
        repeat (2) step(0, 0, 0, 0);
        step(1, 1, 32'h0000_3403, 0);
        chk("t3 flushed", {31'h0, out_valid}, 32'h0);
        chk("t3 im_addr", {22'h0, im_addr}, 32'h100);
        step(1, 0, 0, 0);
        chk("t3 target", out_pc, 32'h3400);
        step(1, 0, 0, 0);
        chk("t3 target+4", out_pc, 32'h3404);

        // PC wrap at the top of the address space
        step(1, 1, 32'hFFFF_FFFC, 0);
        chk("t4 im_addr top", {22'h0, im_addr}, 32'h3FF);
        step(1, 0, 0, 0);
        chk("t4 out_pc top", out_pc, 32'hFFFF_FFFC);
        chk("t4 im_addr wrap", {22'h0, im_addr}, 32'h0);
        step(1, 0, 0, 0);
        chk("t4 out_pc wrap", out_pc, 32'h0);

        // Halt drains two buffered entries, redirect resumes
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("t5 draining", {31'h0, halted}, 32'h0);
        step(1, 0, 0, 0);
        chk("t5 halted", {31'h0, halted}, 32'h1);
        step(1, 0, 0, 1);
        chk("t5 still halted", {31'h0, halted}, 32'h1);
        step(1, 1, 32'h0000_3000, 1);
        chk("t5 redirect+halt", {31'h0, halted}, 32'h0);
        step(1, 0, 0, 0);
        chk("t5 resume", out_pc, 32'h3000);

        // Asynchronous reset between edges
        step(0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 async out_valid", {31'h0, out_valid}, 32'h0);
        chk("t6 async im_addr", {22'h0, im_addr}, 32'h0);
        model_reset();
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_model();
        step(1, 0, 0, 0);
        chk("t6 resume", out_pc, 32'h3000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          rd;
            bit          hq;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 19) == 0);
            hq  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                              : $urandom;
            step(rdy, rd, rpc, hq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
